// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM encoding,
// frame geometry and bit-period derivation.
package uart_tx_fifo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned DATA_BITS  = 8;

  // Clocks per bit; integer truncation, no fractional correction.
  function automatic int unsigned calc_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty/count flags.
// Power-of-two DEPTH; pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       din,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full_q, empty_q;
  logic             push, pop;

  // Acceptance uses the registered flags, so a write into a full FIFO is
  // dropped even when a pop happens on the same edge.
  assign push = wr_en && !full_q;
  assign pop  = rd_en && !empty_q;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == (AW+1)'(DEPTH));
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: bytes queue in a sync_fifo and are
// serialized LSB first with back-to-back frames when data is waiting.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600,
  parameter int unsigned DEPTH    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             data_in,
  input  logic                   wr_en,
  output logic                   tx,
  output logic                   busy,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int unsigned DIV = calc_div(CLK_FREQ, BAUD);
  localparam int unsigned BW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
  localparam logic [2:0]    BIT_LAST  = 3'(DATA_BITS - 1);

  tx_state_e     state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          tx_q, busy_q, overflow_q;

  logic          baud_done, pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full, fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr_en (wr_en),
    .din   (data_in),
    .rd_en (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  assign baud_done = (baud_q == BAUD_LAST);
  // Pop from IDLE, or at the last clock of STOP so the next start bit
  // follows the stop bit with no idle gap.
  assign pop = !fifo_empty &&
               ((state_q == IDLE) || ((state_q == STOP) && baud_done));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          tx_q   <= 1'b1;
          busy_q <= 1'b0;
          if (pop) begin
            shift_q <= fifo_dout;
            bit_q   <= '0;
            baud_q  <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud_q  <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_q <= '0;
            if (bit_q == BIT_LAST) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              shift_q <= shift_q >> 1;
              tx_q    <= shift_q[1];
              bit_q   <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_q <= '0;
            if (pop) begin
              shift_q <= fifo_dout;
              bit_q   <= '0;
              tx_q    <= 1'b0;
              state_q <= START;
            end else begin
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                 overflow_q <= 1'b0;
    else if (wr_en && fifo_full) overflow_q <= 1'b1;
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign full     = fifo_full;
  assign empty    = fifo_empty;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues expected bytes, a
// line monitor decodes frames and compares them in order.
module tb_uart_tx_fifo;

  localparam int DIV   = 16;
  localparam int FRAME = 10 * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       tx, busy, full, empty, overflow;
  logic [2:0] count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  uart_tx_fifo #(
    .CLK_FREQ (16),
    .BAUD     (1),
    .DEPTH    (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data_in  (data_in),
    .wr_en    (wr_en),
    .tx       (tx),
    .busy     (busy),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at posedge+1; drives a one-cycle strobe sampled at the next edge.
  task automatic wr(input logic [7:0] b, input bit accepted);
    data_in = b;
    wr_en   = 1'b1;
    if (accepted) exp_q.push_back(b);
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    data_in = ~b;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    start_q.delete();
  endtask

  task automatic wait_idle(input int maxc, output int n, output int nonempty);
    n = 0;
    nonempty = 0;
    while (busy && n < maxc) begin
      if (!empty) nonempty++;
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) check("idle_timeout", 32'(busy), 32'd0);
  endtask

  // Line monitor: each frame must hold every bit for exactly DIV clocks.
  initial begin
    logic [FRAME-1:0] samp;
    logic [7:0]       got;
    bit               aborted;
    int               unstable;
    forever begin
      @(negedge clk);
      if (!reset && tx === 1'b0) begin
        start_q.push_back(cyc);
        samp    = '0;
        aborted = 1'b0;
        for (int i = 1; i < FRAME; i++) begin
          @(negedge clk);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          samp[i] = tx;
        end
        if (!aborted) begin
          unstable = 0;
          for (int j = 0; j < 10; j++)
            for (int s = 1; s < DIV; s++)
              if (samp[j*DIV+s] !== samp[j*DIV]) unstable++;
          check("bit_hold", 32'(unstable), 32'd0);
          check("stop_bit", 32'(samp[9*DIV]), 32'd1);
          for (int b = 0; b < 8; b++) got[b] = samp[(b+1)*DIV];
          if (exp_q.size() == 0) check("unexpected_frame", 32'(got), 32'h100);
          else                   check("frame_byte", 32'(got), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, got cycle %0d expected < 20000", cyc);
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ne, low;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single frame 0xA5
    start_q.delete();
    wr(8'hA5, 1);
    check("t1_empty_k", 32'(empty), 32'd0);
    check("t1_count_k", 32'(count), 32'd1);
    check("t1_tx_k", 32'(tx), 32'd1);
    @(posedge clk);
    #1;
    check("t1_tx_k1", 32'(tx), 32'd0);
    check("t1_busy_k1", 32'(busy), 32'd1);
    check("t1_empty_k1", 32'(empty), 32'd1);
    wait_idle(400, n, ne);
    check("t1_frame_len", 32'(n), 32'd160);
    check("t1_empty_frame", 32'(ne), 32'd0);
    check("t1_tx_idle", 32'(tx), 32'd1);

    // Three back-to-back frames
    start_q.delete();
    wr(8'h55, 1);
    check("t2_count_a", 32'(count), 32'd1);
    wr(8'h0F, 1);
    check("t2_count_b", 32'(count), 32'd1);
    wr(8'hF0, 1);
    check("t2_count_c", 32'(count), 32'd2);
    repeat (159) @(posedge clk);
    #1;
    check("t2_count_pop1", 32'(count), 32'd1);
    repeat (160) @(posedge clk);
    #1;
    check("t2_count_pop2", 32'(count), 32'd0);
    wait_idle(400, n, ne);
    check("t2_last_frame", 32'(n), 32'd160);
    check("t2_frames", 32'(start_q.size()), 32'd3);
    if (start_q.size() == 3) begin
      check("t2_gap1", 32'(start_q[1] - start_q[0]), 32'd160);
      check("t2_gap2", 32'(start_q[2] - start_q[1]), 32'd160);
    end

    // Overflow while FIFO full
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wr(8'(8'h11 + i), 1);
      if (i == 3) check("t3_full_3q", 32'(full), 32'd0);
    end
    check("t3_full", 32'(full), 32'd1);
    check("t3_count4", 32'(count), 32'd4);
    wr(8'h16, 0);
    check("t3_overflow", 32'(overflow), 32'd1);
    check("t3_count_hold", 32'(count), 32'd4);
    wait_idle(1000, n, ne);
    check("t3_overflow_sticky", 32'(overflow), 32'd1);
    check("t3_frames", 32'(start_q.size()), 32'd5);

    // Write dropped on the same edge as a STOP->START pop
    do_reset();
    check("t4_overflow_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 5; i++) wr(8'(8'h21 + i), 1);
    repeat (156) @(posedge clk);
    #1;
    check("t4_count_pre", 32'(count), 32'd4);
    wr(8'h26, 0);
    check("t4_overflow", 32'(overflow), 32'd1);
    check("t4_count3", 32'(count), 32'd3);
    check("t4_full_clr", 32'(full), 32'd0);
    wait_idle(1000, n, ne);
    check("t4_frames", 32'(start_q.size()), 32'd5);

    // Reset mid-frame
    do_reset();
    wr(8'h31, 1);
    wr(8'h32, 1);
    wr(8'h33, 1);
    check("t5_count2", 32'(count), 32'd2);
    repeat (38) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("t5_tx", 32'(tx), 32'd1);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_empty", 32'(empty), 32'd1);
    check("t5_count", 32'(count), 32'd0);
    reset = 1'b0;
    start_q.delete();
    low = 0;
    repeat (400) begin
      @(posedge clk);
      #1;
      if (tx !== 1'b1) low++;
    end
    check("t5_line_quiet", 32'(low), 32'd0);
    check("t5_no_frames", 32'(start_q.size()), 32'd0);

    // Simultaneous write/pop across pointer wrap
    do_reset();
    wr(8'h01, 1);
    wr(8'h02, 1);
    wr(8'h03, 1);
    check("t6_count_init", 32'(count), 32'd2);
    for (int j = 4; j <= 8; j++) begin
      repeat ((j == 4) ? 158 : 159) @(posedge clk);
      #1;
      wr(8'(j), 1);
      check("t6_count_same", 32'(count), 32'd2);
    end
    wait_idle(1000, n, ne);
    check("t6_frames", 32'(start_q.size()), 32'd8);

    repeat (4) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered 8N1 UART transmitter, the transmit counterpart to the board's UART receive path. Bytes presented on a one-cycle write strobe (switch data, or characters echoed back from the VGA terminal logic) are queued in a small FIFO and serialized on the TX pin (JA_0) at a fixed baud rate. Sits between the `system` top level and the pin, so the transmit side no longer depends on button-level timing.

## Interface
- `CLK_FREQ`, 100_000_000, system clock frequency in Hz
- `BAUD`, 9600, line rate in bits/s; bit period `DIV = CLK_FREQ / BAUD` (integer truncation, 10416 at defaults; must be ≥ 2)
- `DEPTH`, 8, FIFO entries; power of two, ≥ 2

- `clk`  in  1  system clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- `data_in`  in  8  byte to queue
- `wr_en`  in  1  one-cycle write strobe; `data_in` sampled when high
- `tx`  out  1  serial line, idles high
- `busy`  out  1  high while a frame (start..stop) is on the line
- `full`  out  1  FIFO holds `DEPTH` bytes
- `empty`  out  1  FIFO holds 0 bytes
- `count`  out  $clog2(DEPTH)+1  bytes currently queued (excludes the byte being shifted)
- `overflow`  out  1  sticky; set when a write is dropped, cleared only by reset

## Operation
- Reset values: `tx`=1, `busy`=0, `full`=0, `empty`=1, `count`=0, `overflow`=0; FSM in IDLE; pointers zeroed, FIFO contents discarded.
- FIFO: write accepted iff `wr_en` && !`full` (registered `full`, even if a pop occurs the same cycle). Dropped write sets `overflow`, no other state change.
- Simultaneous accepted write and pop: `count` unchanged, both pointers advance. Pointers wrap modulo `DEPTH`.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If !`empty`: pop head into shift register, bit counter=0, baud counter=0 → START.
  - START: `tx`=0 for `DIV` clocks → DATA.
  - DATA: `tx`=shift[0], LSB first; each `DIV` clocks shift right and increment bit counter; after 8th bit → STOP.
  - STOP: `tx`=1 for `DIV` clocks. At end: if !`empty` pop and → START directly (no idle gap); else → IDLE.
- `busy`=1 in START, DATA, STOP.
- Baud counter runs 0..DIV-1 and restarts on every state entry; no fractional correction.

## Timing
- `wr_en` sampled at edge k into empty FIFO with FSM in IDLE: `empty` falls after edge k; pop at edge k+1; `tx` low and `busy` high after edge k+1.
- Every bit exactly `DIV` clocks; frame exactly `10*DIV` clocks; back-to-back frames contiguous (`10*DIV` period).
- `full`/`empty`/`count` are registered, valid the cycle after the causing edge.
- Reset mid-frame: `tx` high and `busy` low after the reset edge; partial frame abandoned, queued bytes lost.
- `data_in` changes after acceptance do not affect queued bytes.

## Structure
- Shared package: FSM state encoding (IDLE/START/DATA/STOP), frame length constant (10), `DIV` derivation function.
- One sub-module: `sync_fifo` (parameters `WIDTH`, `DEPTH`; ports `clk`, `reset`, `wr_en`, `din`, `rd_en`, `dout`, `full`, `empty`, `count`), reusable for a later buffered receiver. FSM, baud counter and shift register stay in `uart_tx_fifo`.

## Test plan
Use `CLK_FREQ`=16, `BAUD`=1 (`DIV`=16), `DEPTH`=4.
- Reset, single write 0xA5 at edge k → `tx` low after k+1; line reads 0,1,0,1,0,0,1,0,1,1 each held 16 clocks; `busy` drops after 160 clocks; `empty`=1 throughout frame.
- Write 0x55, 0x0F, 0xF0 on consecutive cycles → three contiguous frames, 480 clocks, no idle bit between stop and next start; `count` goes 1,2 then decrements at each pop.
- Five writes during first frame (FSM holds 1, FIFO 4) → `full`=1 after 4th queued; 6th write dropped, `overflow`=1 and stays 1 until reset; exactly 5 frames emitted.
- With `full`=1, assert `wr_en` on the same cycle as a STOP→START pop → write dropped, `overflow` set, `count` drops 4→3.
- Reset asserted at clock 40 of a frame with 2 bytes queued → after reset edge `tx`=1, `busy`=0, `empty`=1, `count`=0; no further frames.
- Write and pop same cycle with `count`=2 → `count` stays 2, byte order preserved across pointer wrap (verify 8 sequential bytes 0x01..0x08 emitted in order).
